// File: rtl/ni_ntc_packet_scheduler.sv
// ni_ntc_packet_scheduler
//
// Shares the single core-side packet port of the network interface among the
// per-virtual-network net-to-core packet FIFOs. Each cycle one VN holding a
// rebuilt packet is chosen. Its FIFO head is dequeued with a one-hot consume
// pulse. The packet is then held in a registered valid/ready output stage for
// the cache/directory controller.
//
// Optional feature macro: NPU_NTC_SCHED_PRIO_EN
//   defined   : VN VN_NUM-1 (response network) has strict priority. After
//               MAX_PRIO_BURST consecutive priority grants, one round-robin
//               grant among VNs 0..VN_NUM-2 is forced when any of them waits.
//   undefined : pure round-robin over all VNs (MAX_PRIO_BURST unused).
//
// Ports:
//   clk                 system clock, rising edge
//   reset               asynchronous active-low reset
//   vn_packet_valid     per-VN FIFO non-empty flags
//   vn_packet_in        per-VN FIFO head packets, VN i at [i*PACKET_BODY_SIZE +: PACKET_BODY_SIZE]
//   vn_packet_consumed  one-hot dequeue pulse to the VN FIFOs (combinational)
//   sched_packet_out    registered packet to the controller
//   sched_packet_vn     VN index of sched_packet_out
//   sched_packet_valid  output register holds a packet
//   core_ready          controller accepts the output packet this cycle

module ni_ntc_packet_scheduler #(
    parameter int VN_NUM           = 4,
    parameter int PACKET_BODY_SIZE = 554,
    parameter int MAX_PRIO_BURST   = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [VN_NUM-1:0]                  vn_packet_valid,
    input  logic [VN_NUM*PACKET_BODY_SIZE-1:0] vn_packet_in,
    output logic [VN_NUM-1:0]                  vn_packet_consumed,
    output logic [PACKET_BODY_SIZE-1:0]        sched_packet_out,
    output logic [$clog2(VN_NUM)-1:0]          sched_packet_vn,
    output logic                               sched_packet_valid,
    input  logic                               core_ready
);

    localparam int VN_W = $clog2(VN_NUM);
    localparam logic [VN_W-1:0] LAST_VN = VN_W'(VN_NUM - 1);

`ifdef NPU_NTC_SCHED_PRIO_EN
    localparam int CNT_W = $clog2(MAX_PRIO_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PRIO_BURST);
    // Removes the priority VN from the request set for a forced round-robin grant.
    localparam logic [VN_NUM-1:0] PRIO_MASK = {1'b1, {(VN_NUM-1){1'b0}}};
`endif

    // Round-robin pick: first requester found scanning upward from ptr with
    // wrap. Returns {found, index}.
    function automatic logic [VN_W:0] rr_pick(
        input logic [VN_NUM-1:0] req,
        input logic [VN_W-1:0]   ptr
    );
        logic            found;
        logic [VN_W-1:0] idx;
        int              j;
        found = 1'b0;
        idx   = {VN_W{1'b0}};
        for (int k = 0; k < VN_NUM; k++) begin
            j = (int'(ptr) + k) % VN_NUM;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = VN_W'(j);
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // Pointer to the VN following w, wrapping VN_NUM-1 to 0.
    function automatic logic [VN_W-1:0] next_ptr(input logic [VN_W-1:0] w);
        logic [VN_W-1:0] nxt;
        if (w == LAST_VN) begin
            nxt = {VN_W{1'b0}};
        end else begin
            nxt = w + VN_W'(1);
        end
        return nxt;
    endfunction

    logic                        load_s;
    logic                        gnt_valid_s;
    logic [VN_W-1:0]             gnt_idx_s;
    logic                        prio_grant_s;
    logic                        take_s;
    logic [VN_W:0]               pick_s;
    logic [PACKET_BODY_SIZE-1:0] gnt_packet_s;

    logic                        out_valid_r;
    logic [PACKET_BODY_SIZE-1:0] out_packet_r;
    logic [VN_W-1:0]             out_vn_r;
    logic [VN_W-1:0]             rr_ptr_r;
`ifdef NPU_NTC_SCHED_PRIO_EN
    logic [CNT_W-1:0]            prio_cnt_r;
    logic                        others_req_s;
`endif

    // The output register may be refilled when empty or drained this cycle.
    assign load_s = ~out_valid_r | core_ready;

    // Winner selection (priority VN first when enabled, otherwise round-robin).
    always_comb begin
        gnt_valid_s  = 1'b0;
        gnt_idx_s    = {VN_W{1'b0}};
        prio_grant_s = 1'b0;
        pick_s       = {(VN_W+1){1'b0}};
`ifdef NPU_NTC_SCHED_PRIO_EN
        others_req_s = |vn_packet_valid[VN_NUM-2:0];
        // At the burst limit the priority VN still wins if nobody else waits.
        if (vn_packet_valid[VN_NUM-1] && ((prio_cnt_r < CNT_MAX) || !others_req_s)) begin
            gnt_valid_s  = 1'b1;
            gnt_idx_s    = LAST_VN;
            prio_grant_s = 1'b1;
        end else begin
            pick_s      = rr_pick(vn_packet_valid & ~PRIO_MASK, rr_ptr_r);
            gnt_valid_s = pick_s[VN_W];
            gnt_idx_s   = pick_s[VN_W-1:0];
        end
`else
        pick_s      = rr_pick(vn_packet_valid, rr_ptr_r);
        gnt_valid_s = pick_s[VN_W];
        gnt_idx_s   = pick_s[VN_W-1:0];
`endif
    end

    // A grant is only taken when the output stage can load; reset blocks it.
    assign take_s = load_s & gnt_valid_s & reset;

    // One-hot consume pulse and head-packet mux for the winning VN.
    always_comb begin
        vn_packet_consumed = {VN_NUM{1'b0}};
        gnt_packet_s       = {PACKET_BODY_SIZE{1'b0}};
        for (int i = 0; i < VN_NUM; i++) begin
            if (gnt_idx_s == VN_W'(i)) begin
                vn_packet_consumed[i] = take_s;
                gnt_packet_s          = vn_packet_in[i*PACKET_BODY_SIZE +: PACKET_BODY_SIZE];
            end else begin
                vn_packet_consumed[i] = 1'b0;
            end
        end
    end

    // Output stage: load winner, clear when drained with no request, else hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_r  <= 1'b0;
            out_packet_r <= {PACKET_BODY_SIZE{1'b0}};
            out_vn_r     <= {VN_W{1'b0}};
        end else if (load_s) begin
            if (gnt_valid_s) begin
                out_valid_r  <= 1'b1;
                out_packet_r <= gnt_packet_s;
                out_vn_r     <= gnt_idx_s;
            end else begin
                out_valid_r  <= 1'b0;
            end
        end else begin
            out_valid_r  <= out_valid_r;
            out_packet_r <= out_packet_r;
            out_vn_r     <= out_vn_r;
        end
    end

    // Round-robin pointer advances past every non-priority winner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_r <= {VN_W{1'b0}};
        end else if (take_s && !prio_grant_s) begin
            rr_ptr_r <= next_ptr(gnt_idx_s);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

`ifdef NPU_NTC_SCHED_PRIO_EN
    // Burst counter: counts priority grants, saturates at the limit, clears on others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_cnt_r <= {CNT_W{1'b0}};
        end else if (take_s) begin
            if (!prio_grant_s) begin
                prio_cnt_r <= {CNT_W{1'b0}};
            end else if (prio_cnt_r < CNT_MAX) begin
                prio_cnt_r <= prio_cnt_r + CNT_W'(1);
            end else begin
                prio_cnt_r <= prio_cnt_r;
            end
        end else begin
            prio_cnt_r <= prio_cnt_r;
        end
    end
`endif

    assign sched_packet_valid = out_valid_r;
    assign sched_packet_out   = out_packet_r;
    assign sched_packet_vn    = out_vn_r;

endmodule

// File: tb/tb_ni_ntc_packet_scheduler.sv
// Self-checking bench for ni_ntc_packet_scheduler: per-VN FIFO queues feed the
// DUT. A behavioural model predicts consume pulses and output-stage contents
// every cycle. Directed literal checks pin the model to hand-derived sequences.
module tb_ni_ntc_packet_scheduler;

    localparam int VN_NUM = 4;
    localparam int PW     = 554;
    localparam int MAXB   = 2;

    logic                 clk;
    logic                 reset;
    logic [VN_NUM-1:0]    vn_packet_valid;
    logic [VN_NUM*PW-1:0] vn_packet_in;
    logic [VN_NUM-1:0]    vn_packet_consumed;
    logic [PW-1:0]        sched_packet_out;
    logic [1:0]           sched_packet_vn;
    logic                 sched_packet_valid;
    logic                 core_ready;

    ni_ntc_packet_scheduler #(
        .VN_NUM(VN_NUM), .PACKET_BODY_SIZE(PW), .MAX_PRIO_BURST(MAXB)
    ) dut (
        .clk(clk), .reset(reset),
        .vn_packet_valid(vn_packet_valid), .vn_packet_in(vn_packet_in),
        .vn_packet_consumed(vn_packet_consumed),
        .sched_packet_out(sched_packet_out), .sched_packet_vn(sched_packet_vn),
        .sched_packet_valid(sched_packet_valid), .core_ready(core_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;

    logic [PW-1:0] fifo_q [VN_NUM][$];

    // Model state
    bit            m_valid;
    logic [PW-1:0] m_pkt;
    int            m_vn;
    int            m_ptr;
    int            m_cnt;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    // Which VN must be granted now (-1 for none), derived from the rules.
    function automatic int model_grant();
        logic [VN_NUM-1:0] req;
        int best;
        int bestd;
        int d;
        if (!reset) return -1;
        if (m_valid && !core_ready) return -1;
        req = vn_packet_valid;
`ifdef NPU_NTC_SCHED_PRIO_EN
        if (req[VN_NUM-1] && (m_cnt < MAXB || req[VN_NUM-2:0] == '0)) return VN_NUM - 1;
        req[VN_NUM-1] = 1'b0;
`endif
        best  = -1;
        bestd = VN_NUM;
        for (int i = 0; i < VN_NUM; i++) begin
            d = (i - m_ptr + VN_NUM) % VN_NUM;
            if (req[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_pkt   = '0;
        m_vn    = 0;
        m_ptr   = 0;
        m_cnt   = 0;
    endtask

    task automatic model_update();
        int g;
        if (!reset) return;
        g = model_grant();
        if (!m_valid || core_ready) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_pkt   = fifo_q[g].pop_front();
                m_vn    = g;
`ifdef NPU_NTC_SCHED_PRIO_EN
                if (g == VN_NUM - 1) begin
                    if (m_cnt < MAXB) m_cnt++;
                end else begin
                    m_ptr = (g + 1) % VN_NUM;
                    m_cnt = 0;
                end
`else
                m_ptr = (g + 1) % VN_NUM;
`endif
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < VN_NUM; i++) begin
            vn_packet_valid[i] = (fifo_q[i].size() != 0);
            vn_packet_in[i*PW +: PW] = (fifo_q[i].size() != 0) ? fifo_q[i][0] : '0;
        end
    endtask

    task automatic fill(input int vn, input int n);
        logic [PW-1:0] p;
        for (int k = 0; k < n; k++) begin
            p = '0;
            p[PW-1 -: 8] = 8'(vn + 1);
            p[15:0]      = 16'((vn + 1) * 256 + k);
            fifo_q[vn].push_back(p);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
        drive_inputs();
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < VN_NUM; i++) fifo_q[i].delete();
        core_ready = 1'b0;
        drive_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin : cmp
        int g;
        logic [VN_NUM-1:0] ec;
        g  = model_grant();
        ec = '0;
        if (g >= 0) ec[g] = 1'b1;
        check("consumed", PW'(vn_packet_consumed), PW'(ec));
        check("valid", PW'(sched_packet_valid), PW'(m_valid));
        if (m_valid) begin
            check("vn", PW'(sched_packet_vn), PW'(m_vn));
            check("packet", sched_packet_out, m_pkt);
        end
    end

    logic [3:0] rr_lit [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`ifdef NPU_NTC_SCHED_PRIO_EN
    logic [3:0] pr_lit [6] = '{4'b1000, 4'b1000, 4'b0001, 4'b1000, 4'b1000, 4'b0001};
`else
    logic [3:0] pr_lit [6] = '{4'b0001, 4'b1000, 4'b0001, 4'b1000, 4'b0001, 4'b1000};
`endif

    initial begin
        reset = 1'b0;
        core_ready = 1'b0;
        vn_packet_valid = '0;
        vn_packet_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Idle after reset, core_ready toggling
        check("reset_valid", PW'(sched_packet_valid), '0);
        check("reset_out", sched_packet_out, '0);
        check("reset_vn", PW'(sched_packet_vn), '0);
        for (int k = 0; k < 10; k++) begin
            core_ready = k[0];
            cycle();
        end
        #1;
        check("idle_valid", PW'(sched_packet_valid), '0);
        check("idle_consumed", PW'(vn_packet_consumed), '0);

        // Round-robin over all-valid VNs
        apply_reset();
        for (int i = 0; i < VN_NUM; i++) fill(i, 2);
        core_ready = 1'b1;
        drive_inputs();
        #1;
        for (int k = 0; k < 5; k++) begin
            check("rr_consumed", PW'(vn_packet_consumed), PW'(rr_lit[k]));
            if (k > 0) check("rr_vn", PW'(sched_packet_vn), PW'(k - 1));
            cycle();
            #1;
        end

        // Output held while core_ready is low
        apply_reset();
        fifo_q[2].push_back(PW'(8'hA5));
        fifo_q[2].push_back(PW'(8'h5A));
        core_ready = 1'b1;
        drive_inputs();
        #1;
        check("hold_first", PW'(vn_packet_consumed), PW'(4'b0100));
        cycle();
        core_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("hold_out", sched_packet_out, PW'(8'hA5));
            check("hold_vn", PW'(sched_packet_vn), PW'(2));
            check("hold_consumed", PW'(vn_packet_consumed), '0);
            cycle();
            #1;
        end
        core_ready = 1'b1;
        #1;
        check("release_consumed", PW'(vn_packet_consumed), PW'(4'b0100));
        check("release_out", sched_packet_out, PW'(8'hA5));
        cycle();
        #1;
        check("release_next", sched_packet_out, PW'(8'h5A));

        // Single VN back-to-back
        apply_reset();
        fifo_q[1].push_back(PW'(12'h111));
        fifo_q[1].push_back(PW'(12'h222));
        fifo_q[1].push_back(PW'(12'h333));
        core_ready = 1'b1;
        drive_inputs();
        #1;
        check("b2b_c0", PW'(vn_packet_consumed), PW'(4'b0010));
        cycle();
        #1;
        check("b2b_o0", sched_packet_out, PW'(12'h111));
        check("b2b_c1", PW'(vn_packet_consumed), PW'(4'b0010));
        cycle();
        #1;
        check("b2b_o1", sched_packet_out, PW'(12'h222));
        check("b2b_c2", PW'(vn_packet_consumed), PW'(4'b0010));
        cycle();
        #1;
        check("b2b_o2", sched_packet_out, PW'(12'h333));
        check("b2b_c3", PW'(vn_packet_consumed), '0);
        cycle();
        #1;
        check("b2b_empty", PW'(sched_packet_valid), '0);

        // VN3 and VN0 competing (priority bursts when enabled)
        apply_reset();
        fill(0, 4);
        fill(3, 4);
        core_ready = 1'b1;
        drive_inputs();
        #1;
        for (int k = 0; k < 6; k++) begin
            check("prio_seq", PW'(vn_packet_consumed), PW'(pr_lit[k]));
            cycle();
            #1;
        end

        // Asynchronous reset with a packet in the output stage
        apply_reset();
        for (int i = 0; i < VN_NUM; i++) fill(i, 2);
        core_ready = 1'b1;
        drive_inputs();
        cycle();
        cycle();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("arst_valid", PW'(sched_packet_valid), '0);
        check("arst_out", sched_packet_out, '0);
        check("arst_vn", PW'(sched_packet_vn), '0);
        check("arst_consumed", PW'(vn_packet_consumed), '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive_inputs();
        #1;
        check("arst_first", PW'(vn_packet_consumed), PW'(4'b0001));
        cycle();
        #1;
        check("arst_vn0", PW'(sched_packet_vn), '0);
        check("arst_valid1", PW'(sched_packet_valid), PW'(1));
        cycle();
        #1;

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
